// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared CPU definitions for the fetch path.
package pc_fetch_unit_pkg;
    typedef enum logic [1:0] {S_FETCH, S_VALID, S_DRAIN, S_ERROR} fetch_state_e;
    typedef enum logic [1:0] {NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_JR} npcop_e;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts consecutive enabled cycles; tc flags the MAX_WAIT-th one.
module fetch_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tc
);
    localparam int W = MAX_WAIT > 2 ? $clog2(MAX_WAIT) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= en ? cnt + W'(1) : '0;
    assign tc = en && cnt == W'(MAX_WAIT - 1);
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-outstanding instruction fetch with flush, stall,
// misalignment and memory-timeout detection.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc_in,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);
    fetch_state_e state, state_nxt;
    logic [31:0] fetch_pc;
    logic waiting, timeout, accept, hit;
    assign waiting = (state == S_FETCH || state == S_DRAIN) && !imem_ack && !flush;
    assign accept  = state == S_VALID && !stall && !flush;
    assign hit     = state == S_FETCH && imem_ack && !flush;
    fetch_timer #(.MAX_WAIT(MAX_WAIT)) u_fetch_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (waiting),
        .tc   (timeout)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_FETCH;
        else state <= state_nxt;
    // A flush while a response is still owed must drain it before refetching.
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = flush_addr[1:0] != 2'b00 ? S_ERROR :
                        (state == S_FETCH || state == S_DRAIN) && !imem_ack ? S_DRAIN : S_FETCH;
        else
            case (state)
                S_FETCH: state_nxt = imem_ack ? S_VALID : timeout ? S_ERROR : S_FETCH;
                S_VALID: state_nxt = stall ? S_VALID : npc_in[1:0] != 2'b00 ? S_ERROR : S_FETCH;
                S_DRAIN: state_nxt = imem_ack ? S_FETCH : timeout ? S_ERROR : S_DRAIN;
                default: state_nxt = S_ERROR;
            endcase
    end
    always_comb begin
        imem_req  = rst_n && state == S_FETCH;
        imem_addr = fetch_pc;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            pc_out      <= RESET_PC;
            inst_out    <= '0;
            inst_valid  <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (flush || accept) fetch_pc <= flush ? flush_addr : npc_in;
            if (hit) begin
                inst_out <= imem_rdata;
                pc_out   <= fetch_pc;
            end
            inst_valid <= state_nxt == S_VALID;
            fetch_err  <= state_nxt == S_ERROR;
            if (accept) fetch_count <= fetch_count + 32'd1;
        end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, stall, flush, imem_ack, imem_req, inst_valid, fetch_err;
    logic [31:0] npc_in, flush_addr, imem_rdata, imem_addr, pc_out, inst_out, fetch_count;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc_in     (npc_in),
        .stall      (stall),
        .flush      (flush),
        .flush_addr (flush_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .inst_out   (inst_out),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err),
        .fetch_count(fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_err"}, 32'(fetch_err), 32'd0);
        check({tag, "_pc"}, pc_out, 32'h0000_3000);
        check({tag, "_inst"}, inst_out, 32'd0);
        check({tag, "_count"}, fetch_count, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
        npc_in = '0; flush_addr = '0; imem_rdata = '0;
        tick();
        tick();
        check_reset_values("rst");
        rst_n = 1'b1;
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0000_3000);
        // Response arrives two cycles after the request starts.
        tick();
        tick();
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_held", imem_addr, 32'h0000_3000);
        imem_ack = 1'b1; imem_rdata = 32'h2408_0005;
        stall = 1'b1;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        check("valid1", 32'(inst_valid), 32'd1);
        check("pc1", pc_out, 32'h0000_3000);
        check("inst1", inst_out, 32'h2408_0005);
        check("req_in_valid", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(inst_valid), 32'd1);
            check("stall_inst", inst_out, 32'h2408_0005);
            check("stall_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0; npc_in = 32'h0000_3004;
        tick();
        check("accept_req", 32'(imem_req), 32'd1);
        check("accept_addr", imem_addr, 32'h0000_3004);
        check("accept_count", fetch_count, 32'd1);
        check("accept_valid", 32'(inst_valid), 32'd0);
        // Flush while 0x3004 is outstanding; its late response must be dropped.
        flush = 1'b1; flush_addr = 32'h0000_4180;
        tick();
        flush = 1'b0;
        check("drain_req", 32'(imem_req), 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check("refetch_req", 32'(imem_req), 32'd1);
        check("refetch_addr", imem_addr, 32'h0000_4180);
        check("drop_valid", 32'(inst_valid), 32'd0);
        check("drop_inst", inst_out, 32'h2408_0005);
        check("drop_pc", pc_out, 32'h0000_3000);
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        tick();
        imem_ack = 1'b0;
        check("valid2", 32'(inst_valid), 32'd1);
        check("pc2", pc_out, 32'h0000_4180);
        check("inst2", inst_out, 32'h1111_2222);
        // Misaligned next PC on accept.
        npc_in = 32'h0000_3006;
        tick();
        check("mis_err", 32'(fetch_err), 32'd1);
        check("mis_req", 32'(imem_req), 32'd0);
        check("mis_valid", 32'(inst_valid), 32'd0);
        check("mis_count", fetch_count, 32'd2);
        tick();
        tick();
        check("err_sticky", 32'(fetch_err), 32'd1);
        check("err_req", 32'(imem_req), 32'd0);
        flush = 1'b1; flush_addr = 32'h0000_3000;
        tick();
        flush = 1'b0;
        check("clr_err", 32'(fetch_err), 32'd0);
        check("clr_req", 32'(imem_req), 32'd1);
        check("clr_addr", imem_addr, 32'h0000_3000);
        // Flush and ack together: response discarded, refetch at flush target.
        flush = 1'b1; flush_addr = 32'h0000_5000;
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
        tick();
        flush = 1'b0; imem_ack = 1'b0;
        check("fa_req", 32'(imem_req), 32'd1);
        check("fa_addr", imem_addr, 32'h0000_5000);
        check("fa_valid", 32'(inst_valid), 32'd0);
        check("fa_inst", inst_out, 32'h1111_2222);
        flush = 1'b1; flush_addr = 32'h0000_5002;
        tick();
        check("bad_flush_err", 32'(fetch_err), 32'd1);
        check("bad_flush_req", 32'(imem_req), 32'd0);
        flush_addr = 32'h0000_6000;
        tick();
        flush = 1'b0;
        check("good_flush_addr", imem_addr, 32'h0000_6000);
        check("good_flush_err", 32'(fetch_err), 32'd0);
        // Timeout: error only after the sixteenth cycle without ack.
        repeat (15) tick();
        check("to_15_err", 32'(fetch_err), 32'd0);
        check("to_15_req", 32'(imem_req), 32'd1);
        tick();
        check("to_16_err", 32'(fetch_err), 32'd1);
        check("to_16_req", 32'(imem_req), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst2");
        tick();
        rst_n = 1'b1;
        #1;
        check("rst2_req", 32'(imem_req), 32'd1);
        check("rst2_addr", imem_addr, 32'h0000_3000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
